// File: rtl/dp_pkg.sv
// Shared encodings for the multicycle ARM datapath: operand/result mux selects,
// immediate formats and ALU operations.
package dp_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        SrcbReg  = 2'b00,
        SrcbImm  = 2'b01,
        SrcbFour = 2'b10
    } srcb_e;

    typedef enum logic [1:0] {
        ResAluOut = 2'b00,
        ResData   = 2'b01,
        ResAlu    = 2'b10
    } res_e;

    typedef enum logic [1:0] {
        ImmByte   = 2'b00,
        ImmWord12 = 2'b01,
        ImmBranch = 2'b10
    } imm_e;

    typedef enum logic [3:0] {
        AluAdd = 4'h0,
        AluSub = 4'h1,
        AluAnd = 4'h2,
        AluOrr = 4'h3,
        AluEor = 4'h4,
        AluAdc = 4'h5,
        AluSbc = 4'h6,
        AluRsb = 4'h7,
        AluMov = 4'h8
    } alu_e;

endpackage

// File: rtl/mem_handshake.sv
// Memory req/ack handshake: stall generation plus a watchdog that raises a sticky
// error when an access stays unacknowledged for TIMEOUT cycles.
module mem_handshake #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_read,
    input  logic mem_write,
    input  logic mem_ack,
    output logic mem_req,
    output logic stall,
    output logic ack,
    output logic mem_err
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    assign mem_req = (mem_read | mem_write) & ~reset;
    assign stall   = mem_req & ~mem_ack;
    // An ack with no request outstanding is meaningless and must not capture data.
    assign ack     = mem_req & mem_ack;
    assign mem_err = err_q;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (TIMEOUT > 0) begin
            if (!stall) begin
                cnt_d = '0;
            end else if (cnt_q < CntW'(TIMEOUT)) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (stall && (cnt_d == CntW'(TIMEOUT))) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle ARM datapath: PC, IR, data, A/B and ALUOut registers around a shared
// memory port; every register holds while the memory handshake stalls.
module mc_datapath
    import dp_pkg::*;
#(
    parameter int unsigned      WIDTH    = DefaultWidth,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      TIMEOUT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic             IRWrite,
    input  logic             RegWrite,
    input  logic             AdrSrc,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [1:0]       RegSrc,
    input  logic [1:0]       ImmSrc,
    input  logic             ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic [1:0]       ResultSrc,
    input  logic [3:0]       ALUControl,
    input  logic             CarryIn,
    output logic [3:0]       ALUFlags,
    output logic [31:0]      Instr,
    output logic [WIDTH-1:0] Adr,
    output logic [WIDTH-1:0] WriteData,
    input  logic [WIDTH-1:0] ReadData,
    output logic             MemReq,
    input  logic             MemAck,
    output logic             Stall,
    output logic             MemErr
);

    logic [WIDTH-1:0] pc_q, pc_d, data_q, data_d, a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic [31:0]      ir_q, ir_d;
    logic [WIDTH-1:0] rf_q [0:14];
    logic [WIDTH-1:0] rf_d [0:14];

    logic             stall, ack;
    logic [3:0]       ra1, ra2, wa;
    logic [WIDTH-1:0] rd1, rd2, ext_imm, src_a, src_b, result, alu_result;
    logic [WIDTH-1:0] op_x, op_y, logic_res;
    logic [WIDTH:0]   sum;
    logic             cin, arith;

    mem_handshake #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_handshake (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (MemRead),
        .mem_write (MemWrite),
        .mem_ack   (MemAck),
        .mem_req   (MemReq),
        .stall     (stall),
        .ack       (ack),
        .mem_err   (MemErr)
    );

    assign Stall     = stall;
    assign Instr     = ir_q;
    assign WriteData = b_q;
    assign Adr       = AdrSrc ? result : pc_q;

    // Register file: r15 is not stored, it reads back the current Result.
    assign ra1 = RegSrc[0] ? 4'd15 : ir_q[19:16];
    assign ra2 = RegSrc[1] ? ir_q[15:12] : ir_q[3:0];
    assign wa  = ir_q[15:12];
    assign rd1 = (ra1 == 4'd15) ? result : rf_q[ra1];
    assign rd2 = (ra2 == 4'd15) ? result : rf_q[ra2];

    always_comb begin
        rf_d = rf_q;
        if (RegWrite && !stall && (wa != 4'd15)) begin
            rf_d[wa] = result;
        end
    end

    always_comb begin
        case (ImmSrc)
            ImmByte:   ext_imm = {{(WIDTH - 8){1'b0}}, ir_q[7:0]};
            ImmWord12: ext_imm = {{(WIDTH - 12){1'b0}}, ir_q[11:0]};
            ImmBranch: ext_imm = {{(WIDTH - 26){ir_q[23]}}, ir_q[23:0], 2'b00};
            default:   ext_imm = '0;
        endcase
    end

    assign src_a = ALUSrcA ? pc_q : a_q;

    always_comb begin
        case (ALUSrcB)
            SrcbReg:  src_b = b_q;
            SrcbImm:  src_b = ext_imm;
            SrcbFour: src_b = WIDTH'(4);
            default:  src_b = '0;
        endcase
    end

    // Arithmetic ops share one adder; subtraction is x + ~y + 1 so C means no borrow.
    always_comb begin
        op_x      = src_a;
        op_y      = src_b;
        cin       = 1'b0;
        arith     = 1'b1;
        logic_res = '0;
        case (ALUControl)
            AluAdd: arith = 1'b1;
            AluSub: begin op_y = ~src_b; cin = 1'b1; end
            AluAdc: cin = CarryIn;
            AluSbc: begin op_y = ~src_b; cin = CarryIn; end
            AluRsb: begin op_x = src_b; op_y = ~src_a; cin = 1'b1; end
            AluAnd: begin arith = 1'b0; logic_res = src_a & src_b; end
            AluOrr: begin arith = 1'b0; logic_res = src_a | src_b; end
            AluEor: begin arith = 1'b0; logic_res = src_a ^ src_b; end
            AluMov: begin arith = 1'b0; logic_res = src_b; end
            default: arith = 1'b0;
        endcase
        sum         = {1'b0, op_x} + {1'b0, op_y} + {{WIDTH{1'b0}}, cin};
        alu_result  = arith ? sum[WIDTH-1:0] : logic_res;
        ALUFlags[3] = alu_result[WIDTH-1];
        ALUFlags[2] = (alu_result == '0);
        ALUFlags[1] = arith ? sum[WIDTH] : CarryIn;
        ALUFlags[0] = arith & (op_x[WIDTH-1] == op_y[WIDTH-1])
                            & (sum[WIDTH-1] != op_x[WIDTH-1]);
    end

    always_comb begin
        case (ResultSrc)
            ResAluOut: result = alu_out_q;
            ResData:   result = data_q;
            ResAlu:    result = alu_result;
            default:   result = alu_out_q;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        data_d    = data_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        if (!stall) begin
            if (PCWrite) pc_d = result;
            if (IRWrite && ack) ir_d = ReadData[31:0];
            if (MemRead && ack) data_d = ReadData;
            a_d       = rd1;
            b_d       = rd2;
            alu_out_d = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            data_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            data_q    <= data_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
        end
    end

    always_ff @(posedge clk) begin
        rf_q <= rf_d;
    end

endmodule
